// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch/execute sequencer.
//   - default widths for the program counter and the instruction word
//   - opcode constants (4-bit, taken from the top of the instruction word)
//   - sequencer FSM state enum
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 10;
  localparam int CNT_W       = 16;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_MOV   = 4'd8;
  localparam logic [3:0] OP_JUMP  = 4'd9;
  localparam logic [3:0] OP_BEQ   = 4'd10;
  localparam logic [3:0] OP_INCR  = 4'd11;
  localparam logic [3:0] OP_BNE   = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Combinational next-program-counter calculation.
//   i_pc      : current program counter
//   i_ir_lo   : low six bits of the current instruction (jump target /
//               branch offset field)
//   i_jump    : absolute jump within the current 64-word page
//   i_beq     : branch if ZERO
//   i_bne     : branch if not ZERO
//   i_zero    : ALU result-equals-zero flag
//   o_next_pc : PC to load when the instruction retires
// ---------------------------------------------------------------------------
module pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [5:0]      i_ir_lo,
  input  logic            i_jump,
  input  logic            i_beq,
  input  logic            i_bne,
  input  logic            i_zero,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_offset;
  logic            w_taken;

  assign w_pc_inc = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
  // 4-bit two's-complement displacement, relative to PC+1
  assign w_offset = {{(PC_W-4){i_ir_lo[3]}}, i_ir_lo[3:0]};
  assign w_taken  = (i_beq & i_zero) | (i_bne & ~i_zero);

  always_comb begin
    o_next_pc = w_pc_inc;
    // jump wins over any branch that happens to be asserted alongside it
    if (i_jump) begin
      o_next_pc = {i_pc[PC_W-1:6], i_ir_lo};
    end else if (w_taken) begin
      o_next_pc = w_pc_inc + w_offset;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch / execute sequencer: IDLE -> FETCH -> EXEC -> FETCH ...
// until a HALT instruction parks it in HALTED.
//   CLK, RST_N        : clock, asynchronous active-low reset
//   START             : pulse in IDLE/HALTED restarts execution at PC=0
//   IMEM_REQ/ADDR     : instruction read request, address = PC
//   IMEM_ACK/RDATA    : read completion and fetched instruction
//   OPCODE, IR        : current instruction (to the external decoder)
//   JUMP/BEQ/BNE/HALT : decoder outputs, sampled in EXEC
//   ZERO              : ALU zero flag, sampled in EXEC
//   EXEC_EN           : one-cycle execute strobe
//   PC, HALTED        : program counter, halted status
//   INSTR_CNT         : retired-instruction counter (HALT not counted)
// ---------------------------------------------------------------------------
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  output logic               IMEM_REQ,
  output logic [PC_W-1:0]    IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  output logic [3:0]         OPCODE,
  output logic [INSTR_W-1:0] IR,
  input  logic               JUMP,
  input  logic               BEQ,
  input  logic               BNE,
  input  logic               HALT,
  input  logic               ZERO,
  output logic               EXEC_EN,
  output logic [PC_W-1:0]    PC,
  output logic               HALTED,
  output logic [CNT_W-1:0]   INSTR_CNT
);

  state_t             r_state;
  state_t             w_state_next;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_next;
  logic [PC_W-1:0]    w_pc_calc;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_ir_next;
  logic [CNT_W-1:0]   r_instr_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .i_pc      (r_pc),
    .i_ir_lo   (r_ir[5:0]),
    .i_jump    (JUMP),
    .i_beq     (BEQ),
    .i_bne     (BNE),
    .i_zero    (ZERO),
    .o_next_pc (w_pc_calc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_ir        <= w_ir_next;
      r_instr_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_cnt_next   = r_instr_cnt;
    IMEM_REQ     = 1'b0;
    EXEC_EN      = 1'b0;
    HALTED       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        HALTED = (r_state == ST_HALTED);
        if (START) begin
          w_state_next = ST_FETCH;
          w_pc_next    = '0;
          w_cnt_next   = '0;
        end
      end
      ST_FETCH: begin
        // address is simply PC, so it stays stable for the whole wait
        IMEM_REQ = 1'b1;
        if (IMEM_ACK) begin
          w_ir_next    = IMEM_RDATA;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        EXEC_EN = 1'b1;
        if (HALT) begin
          // HALT does not retire and leaves PC pointing at itself
          w_state_next = ST_HALTED;
        end else begin
          w_state_next = ST_FETCH;
          w_pc_next    = w_pc_calc;
          w_cnt_next   = r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign IMEM_ADDR = r_pc;
  assign PC        = r_pc;
  assign IR        = r_ir;
  assign OPCODE    = r_ir[INSTR_W-1 -: 4];
  assign INSTR_CNT = r_instr_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: directed vector table for next-PC
// rules, hand-written multi-cycle sequences, and a randomized program run
// against a behavioural instruction-level model.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [9:0] I_INCR = 10'h2C0;
  localparam logic [9:0] I_HALT = 10'h000;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        IMEM_REQ;
  logic [7:0]  IMEM_ADDR;
  logic        IMEM_ACK;
  logic [9:0]  IMEM_RDATA;
  logic [3:0]  OPCODE;
  logic [9:0]  IR;
  logic        JUMP, BEQ, BNE, HALT, ZERO;
  logic        EXEC_EN;
  logic [7:0]  PC;
  logic        HALTED;
  logic [15:0] INSTR_CNT;

  fetch_sequencer #(.PC_W(8), .INSTR_W(10)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_ACK   (IMEM_ACK),
    .IMEM_RDATA (IMEM_RDATA),
    .OPCODE     (OPCODE),
    .IR         (IR),
    .JUMP       (JUMP),
    .BEQ        (BEQ),
    .BNE        (BNE),
    .HALT       (HALT),
    .ZERO       (ZERO),
    .EXEC_EN    (EXEC_EN),
    .PC         (PC),
    .HALTED     (HALTED),
    .INSTR_CNT  (INSTR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // instruction-level model state
  logic [9:0] mem [256];
  int m_pc;
  int m_cnt;
  int m_halted;
  logic [9:0] last_ir;

  typedef struct {
    int         pc;
    logic [9:0] ins;
    logic       xbeq;
    logic       z;
    int         exp_pc;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    START = 0; IMEM_ACK = 0; IMEM_RDATA = '0;
    JUMP = 0; BEQ = 0; BNE = 0; HALT = 0; ZERO = 0;
  endtask

  // called at a negedge; asserts reset and checks the outputs immediately
  task automatic apply_reset();
    RST_N = 0;
    #1;
    chk("rst_req",    32'(IMEM_REQ),  0);
    chk("rst_exec",   32'(EXEC_EN),   0);
    chk("rst_halted", 32'(HALTED),    0);
    chk("rst_pc",     32'(PC),        0);
    chk("rst_ir",     32'(IR),        0);
    chk("rst_cnt",    32'(INSTR_CNT), 0);
    m_pc = 0; m_cnt = 0; m_halted = 0; last_ir = '0;
    @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic fill_incr();
    for (int i = 0; i < 256; i++) mem[i] = I_INCR;
  endtask

  // called at a negedge in IDLE or HALTED
  task automatic start_prog();
    START = 1;
    @(negedge CLK);
    START = 0;
    m_pc = 0; m_cnt = 0; m_halted = 0;
    chk("start_req",  32'(IMEM_REQ),  1);
    chk("start_addr", 32'(IMEM_ADDR), 0);
    chk("start_cnt",  32'(INSTR_CNT), 0);
  endtask

  // one full fetch + execute; called at a negedge while in FETCH
  task automatic do_instr(input int lat, input logic xbeq, input logic z, input logic noise);
    logic [9:0] ins;
    logic [3:0] op;
    logic j, bq, bn, h;
    int off;
    for (int k = 0; k <= lat; k++) begin
      chk("fetch_req",  32'(IMEM_REQ),  1);
      chk("fetch_addr", 32'(IMEM_ADDR), 32'(m_pc));
      chk("fetch_noexec", 32'(EXEC_EN), 0);
      if (k < lat) begin
        IMEM_ACK = 0;
        IMEM_RDATA = 10'($urandom);
        if (noise) {START, JUMP, BEQ, BNE, HALT} = 5'($urandom);
        @(negedge CLK);
      end
    end
    ins = mem[m_pc];
    IMEM_ACK = 1;
    IMEM_RDATA = ins;
    if (noise) {START, JUMP, BEQ, BNE, HALT} = 5'($urandom);
    @(negedge CLK);
    IMEM_ACK = noise ? 1'($urandom) : 1'b0;
    IMEM_RDATA = 10'($urandom);
    chk("exec_en",  32'(EXEC_EN), 1);
    chk("exec_ir",  32'(IR),      32'(ins));
    chk("exec_op",  32'(OPCODE),  32'(ins[9:6]));
    op = ins[9:6];
    h  = (op == 4'd0);
    j  = (op == 4'd9);
    bq = (op == 4'd10) | xbeq;
    bn = (op == 4'd12);
    JUMP = j; BEQ = bq; BNE = bn; HALT = h; ZERO = z;
    START = noise ? 1'($urandom) : 1'b0;
    last_ir = ins;
    if (h) begin
      m_halted = 1;
    end else begin
      m_cnt = (m_cnt + 1) & 32'hFFFF;
      if (j) begin
        m_pc = (m_pc & 32'hC0) | int'(ins[5:0]);
      end else if ((bq && z) || (bn && !z)) begin
        off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
        m_pc = (m_pc + 1 + off) & 32'hFF;
      end else begin
        m_pc = (m_pc + 1) & 32'hFF;
      end
    end
    @(negedge CLK);
    clear_inputs();
    chk("ret_pc",     32'(PC),        32'(m_pc));
    chk("ret_cnt",    32'(INSTR_CNT), 32'(m_cnt));
    chk("ret_halted", 32'(HALTED),    32'(m_halted));
    chk("ret_req",    32'(IMEM_REQ),  32'(m_halted == 0));
    chk("ret_exec",   32'(EXEC_EN),   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{pc: 10,   ins: 10'h28E, xbeq: 0, z: 1, exp_pc: 9};
    vecs[1]  = '{pc: 10,   ins: 10'h28E, xbeq: 0, z: 0, exp_pc: 11};
    vecs[2]  = '{pc: 10,   ins: 10'h303, xbeq: 0, z: 0, exp_pc: 14};
    vecs[3]  = '{pc: 10,   ins: 10'h303, xbeq: 0, z: 1, exp_pc: 11};
    vecs[4]  = '{pc: 'h47, ins: 10'h252, xbeq: 0, z: 0, exp_pc: 'h52};
    vecs[5]  = '{pc: 'h47, ins: 10'h252, xbeq: 1, z: 1, exp_pc: 'h52};
    vecs[6]  = '{pc: 'hFF, ins: 10'h2C0, xbeq: 0, z: 0, exp_pc: 'h00};
    vecs[7]  = '{pc: 5,    ins: 10'h287, xbeq: 0, z: 1, exp_pc: 13};
    vecs[8]  = '{pc: 2,    ins: 10'h288, xbeq: 0, z: 1, exp_pc: 'hFB};
    vecs[9]  = '{pc: 'hFF, ins: 10'h301, xbeq: 0, z: 0, exp_pc: 'h01};
    vecs[10] = '{pc: 'hC5, ins: 10'h27F, xbeq: 0, z: 0, exp_pc: 'hFF};

    RST_N = 1;
    clear_inputs();
    m_pc = 0; m_cnt = 0; m_halted = 0; last_ir = '0;
    @(negedge CLK);

    // INCR, INCR, HALT; stays idle until START
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      IMEM_ACK = 1; IMEM_RDATA = 10'h155;
      @(negedge CLK);
      chk("idle_req", 32'(IMEM_REQ), 0);
      chk("idle_ir",  32'(IR),       0);
    end
    IMEM_ACK = 0;
    fill_incr();
    mem[2] = I_HALT;
    start_prog();
    do_instr(0, 0, 0, 0);
    chk("s1_pc1", 32'(PC), 1);
    do_instr(0, 0, 0, 0);
    chk("s1_pc2", 32'(PC), 2);
    do_instr(0, 0, 0, 0);
    chk("s1_halted", 32'(HALTED),    1);
    chk("s1_pc_h",   32'(PC),        2);
    chk("s1_cnt",    32'(INSTR_CNT), 2);
    // ACK while halted must not touch IR
    IMEM_ACK = 1; IMEM_RDATA = 10'h3FF;
    repeat (2) @(negedge CLK);
    IMEM_ACK = 0;
    chk("halt_ack_ir", 32'(IR),     32'(I_HALT));
    chk("halt_hold",   32'(HALTED), 1);
    chk("halt_pc",     32'(PC),     2);

    // restart from HALTED, then a 3-cycle ACK delay at PC=5
    mem[2] = I_INCR;
    start_prog();
    for (int i = 0; i < 5; i++) do_instr(0, 0, 0, 0);
    chk("s2_pc5", 32'(PC), 5);
    do_instr(3, 0, 0, 0);
    chk("s2_pc6", 32'(PC), 6);

    // reset in the middle of a pending fetch
    @(negedge CLK);
    chk("s3_req_before", 32'(IMEM_REQ), 1);
    apply_reset();
    IMEM_ACK = 1; IMEM_RDATA = 10'h2AA;
    repeat (2) begin
      @(negedge CLK);
      chk("s3_idle_req", 32'(IMEM_REQ), 0);
      chk("s3_idle_ir",  32'(IR),       0);
      chk("s3_idle_pc",  32'(PC),       0);
    end
    IMEM_ACK = 0;

    // retired-instruction counter wrap
    start_prog();
    force dut.r_instr_cnt = 16'hFFFF;
    #1;
    release dut.r_instr_cnt;
    m_cnt = 32'hFFFF;
    do_instr(0, 0, 0, 0);
    chk("cnt_wrap", 32'(INSTR_CNT), 0);

    // next-PC vector table
    for (int v = 0; v < 11; v++) begin
      @(negedge CLK);
      apply_reset();
      fill_incr();
      mem[vecs[v].pc] = vecs[v].ins;
      start_prog();
      for (int i = 0; i < vecs[v].pc; i++) do_instr(0, 0, 0, 0);
      do_instr(0, vecs[v].xbeq, vecs[v].z, 0);
      chk($sformatf("vec%0d_pc", v), 32'(PC), 32'(vecs[v].exp_pc));
    end

    // randomized program with random latency and noise on ignored inputs
    @(negedge CLK);
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if (r < 3)       op = 4'd0;
      else if (r < 40) op = 4'd11;
      else if (r < 55) op = 4'd9;
      else if (r < 70) op = 4'd10;
      else if (r < 85) op = 4'd12;
      else             op = 4'($urandom_range(1, 8));
      mem[i] = {op, 6'($urandom)};
    end
    start_prog();
    for (int n = 0; n < 400; n++) begin
      if (m_halted != 0) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge CLK);
          chk("rnd_halt_hold", 32'(HALTED), 1);
          chk("rnd_halt_pc",   32'(PC),     32'(m_pc));
        end
        start_prog();
      end
      do_instr($urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
